// File: rtl/btn_pkg.sv
// Shared types and defaults for the button conditioner.
// Optional release strobes are enabled by defining BTN_RELEASE_PULSE_EN.
package btn_pkg;

  localparam int DEBOUNCE_DEFAULT = 100000;

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    IDLE      = 3'd1,
    PRESS_CHK = 3'd2,
    HELD      = 3'd3,
    REL_CHK   = 3'd4
  } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, saturating run counter and debounce FSM.
// BTN_RELEASE_PULSE_EN adds a one-cycle strobe when a release is confirmed.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic pulse
`ifdef BTN_RELEASE_PULSE_EN
  ,
  output logic rel_pulse
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          s;
  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign s       = sync[1];
  assign cnt_inc = (cnt == LAST) ? cnt : cnt + 1'b1;

  // The cycle that enters PRESS_CHK/REL_CHK counts as the first stable sample,
  // so the check states finish when the incremented count reaches LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync      <= '0;
      state     <= ARM;
      cnt       <= '0;
      level     <= 1'b0;
      pulse     <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      rel_pulse <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], btn};
      pulse     <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      rel_pulse <= 1'b0;
`endif
      case (state)
        ARM: begin
          if (s) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        IDLE: begin
          if (s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_inc == LAST) begin
            state <= HELD;
            cnt   <= '0;
            level <= 1'b1;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HELD: begin
          if (!s) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt_inc == LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            level     <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
            rel_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= ARM;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Two independent debounced button channels (start, react).
// Define BTN_RELEASE_PULSE_EN to expose start_rel_pulse / react_rel_pulse.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start_btn,
  input  logic react_btn,
  output logic start_level,
  output logic react_level,
  output logic start_pulse,
  output logic react_pulse
`ifdef BTN_RELEASE_PULSE_EN
  ,
  output logic start_rel_pulse,
  output logic react_rel_pulse
`endif
);

  btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk       (clk),
    .reset     (reset),
    .btn       (start_btn),
    .level     (start_level),
    .pulse     (start_pulse)
`ifdef BTN_RELEASE_PULSE_EN
    ,
    .rel_pulse (start_rel_pulse)
`endif
  );

  btn_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_react (
    .clk       (clk),
    .reset     (reset),
    .btn       (react_btn),
    .level     (react_level),
    .pulse     (react_pulse)
`ifdef BTN_RELEASE_PULSE_EN
    ,
    .rel_pulse (react_rel_pulse)
`endif
  );

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DEBOUNCE_CYCLES=4): directed cases plus
// random button activity against a run-length reference model.
module tb_btn_conditioner;

  localparam int D = 4;

  logic clk;
  logic reset;
  logic start_btn;
  logic react_btn;
  logic start_level;
  logic react_level;
  logic start_pulse;
  logic react_pulse;
`ifdef BTN_RELEASE_PULSE_EN
  logic start_rel_pulse;
  logic react_rel_pulse;
`endif

  btn_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .start_level (start_level),
    .react_level (react_level),
    .start_pulse (start_pulse),
    .react_pulse (react_pulse)
`ifdef BTN_RELEASE_PULSE_EN
    ,
    .start_rel_pulse (start_rel_pulse),
    .react_rel_pulse (react_rel_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  // Reference model: raw input reaches the decision logic two cycles late;
  // a level change is accepted once the last D seen samples all hold the new value.
  bit m_pipe0 [2];
  bit m_pipe1 [2];
  bit run_val [2];
  int run_len [2];
  bit m_armed [2];
  bit m_level [2];
  bit m_pulse [2];
  bit m_rel   [2];

  int sp_cnt, rp_cnt, srel_cnt;
  int last_sp, last_rp, last_srel, last_sfall;
  bit prev_sl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    for (int ch = 0; ch < 2; ch++) begin
      bit raw, s;
      raw = (ch == 0) ? start_btn : react_btn;
      m_pulse[ch] = 1'b0;
      m_rel[ch]   = 1'b0;
      if (reset) begin
        m_pipe0[ch] = 1'b0;
        m_pipe1[ch] = 1'b0;
        run_len[ch] = 0;
        run_val[ch] = 1'b0;
        m_armed[ch] = 1'b0;
        m_level[ch] = 1'b0;
      end else begin
        s = m_pipe1[ch];
        m_pipe1[ch] = m_pipe0[ch];
        m_pipe0[ch] = raw;
        if (run_len[ch] > 0 && run_val[ch] == s) begin
          if (run_len[ch] < 1000000) run_len[ch]++;
        end else begin
          run_val[ch] = s;
          run_len[ch] = 1;
        end
        if (run_len[ch] >= D) begin
          if (!m_armed[ch]) begin
            if (s == 1'b0) m_armed[ch] = 1'b1;
          end else if (!m_level[ch] && s) begin
            m_level[ch] = 1'b1;
            m_pulse[ch] = 1'b1;
          end else if (m_level[ch] && !s) begin
            m_level[ch] = 1'b0;
            m_rel[ch]   = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("start_level", start_level, m_level[0]);
    chk("react_level", react_level, m_level[1]);
    chk("start_pulse", start_pulse, m_pulse[0]);
    chk("react_pulse", react_pulse, m_pulse[1]);
`ifdef BTN_RELEASE_PULSE_EN
    chk("start_rel_pulse", start_rel_pulse, m_rel[0]);
    chk("react_rel_pulse", react_rel_pulse, m_rel[1]);
    if (start_rel_pulse === 1'b1) begin srel_cnt++; last_srel = cyc; end
`endif
    if (start_pulse === 1'b1) begin sp_cnt++; last_sp = cyc; end
    if (react_pulse === 1'b1) begin rp_cnt++; last_rp = cyc; end
    if (prev_sl && start_level === 1'b0) last_sfall = cyc;
    prev_sl = (start_level === 1'b1);
  endtask

  task automatic clr_counts();
    sp_cnt = 0; rp_cnt = 0; srel_cnt = 0;
    last_sp = -100; last_rp = -100; last_srel = -100; last_sfall = -100;
  endtask

  initial begin
    int t0;
    reset = 1'b1; start_btn = 1'b0; react_btn = 1'b0;
    prev_sl = 1'b0;
    clr_counts();
    repeat (2) tick();
    chk("reset_start_level", start_level, 0);
    chk("reset_start_pulse", start_pulse, 0);
    reset = 1'b0;

    // Clean press: pulse and level rise D+2 cycles after the raw edge
    repeat (D + 2) tick();
    clr_counts();
    start_btn = 1'b1; t0 = cyc;
    repeat (20) tick();
    chk("press_pulse_count", sp_cnt, 1);
    chk("press_latency", last_sp - t0, D + 2);
    chk("press_level_held", start_level, 1);
    start_btn = 1'b0; t0 = cyc;
    repeat (20) tick();
    chk("release_latency", last_sfall - t0, D + 2);
    chk("release_level", start_level, 0);
`ifdef BTN_RELEASE_PULSE_EN
    chk("rel_pulse_count", srel_cnt, 1);
    chk("rel_pulse_latency", last_srel - t0, D + 2);
    chk("rel_with_level_drop", last_srel, last_sfall);
`endif

    // Bouncing react button settles high
    clr_counts();
    react_btn = 1'b1; tick();
    react_btn = 1'b0; tick();
    react_btn = 1'b1; tick();
    react_btn = 1'b0; tick();
    react_btn = 1'b1; t0 = cyc;
    repeat (20) tick();
    chk("bounce_pulse_count", rp_cnt, 1);
    chk("bounce_latency", last_rp - t0, D + 2);
    react_btn = 1'b0;
    repeat (12) tick();

    // Button held through reset must be released before a press counts
    start_btn = 1'b1; reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0; clr_counts();
    repeat (50) tick();
    chk("held_thru_reset_no_pulse", sp_cnt, 0);
    start_btn = 1'b0;
    repeat (10) tick();
    start_btn = 1'b1;
    repeat (20) tick();
    chk("after_rearm_pulse_count", sp_cnt, 1);
    start_btn = 1'b0;
    repeat (12) tick();

    // Simultaneous presses
    clr_counts();
    start_btn = 1'b1; react_btn = 1'b1;
    repeat (20) tick();
    chk("simul_start_count", sp_cnt, 1);
    chk("simul_react_count", rp_cnt, 1);
    chk("simul_same_cycle", last_sp, last_rp);
    start_btn = 1'b0; react_btn = 1'b0;
    repeat (12) tick();

    // Reset two cycles into PRESS_CHK aborts the press
    clr_counts();
    start_btn = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("abort_level", start_level, 0);
    chk("abort_pulse", start_pulse, 0);
    reset = 1'b0;
    repeat (20) tick();
    chk("abort_no_pulse", sp_cnt, 0);
    start_btn = 1'b0;
    repeat (10) tick();
    start_btn = 1'b1;
    repeat (12) tick();
    chk("abort_then_press", sp_cnt, 1);
    start_btn = 1'b0;
    repeat (12) tick();

    // Random activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) react_btn = ~react_btn;
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 100000, is the consecutive stable synchronized cycles required to accept a level change (10 ms at 10 MHz); legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all logic SHALL run on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_btn  input  1  raw asynchronous start button, 1 = pressed.
REQ-005 react_btn  input  1  raw asynchronous react button, 1 = pressed.
REQ-006 start_level  output  1  debounced start button level.
REQ-007 react_level  output  1  debounced react button level.
REQ-008 start_pulse  output  1  one-cycle strobe on an accepted start press.
REQ-009 react_pulse  output  1  one-cycle strobe on an accepted react press.
REQ-010 start_rel_pulse, react_rel_pulse  output  1 each  one-cycle release strobes; present only per REQ-026.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL run an independent FSM with states ARM, IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-013 ARM: the FSM SHALL go to IDLE only after the synchronized input reads 0 for DEBOUNCE_CYCLES consecutive cycles; a 1 SHALL clear the counter.
REQ-014 IDLE: a synchronized 1 SHALL go to PRESS_CHK with the counter cleared.
REQ-015 PRESS_CHK: the counter SHALL increment while the input is 1, and a 0 SHALL return to IDLE; when the count reaches DEBOUNCE_CYCLES-1 with the input at 1, the FSM SHALL go to HELD, set the level to 1, and assert the press pulse for that one cycle.
REQ-016 HELD: a synchronized 0 SHALL go to REL_CHK with the counter cleared; no pulse SHALL repeat while the button stays held.
REQ-017 REL_CHK: mirror of PRESS_CHK; on confirmed 0 the FSM SHALL go to IDLE and clear the level, and a 1 SHALL return to HELD.
REQ-018 Latency from a clean raw 0->1 edge to the pulse SHALL be exactly DEBOUNCE_CYCLES+2 cycles, and the same SHALL hold for release to level drop.
REQ-019 The counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide, SHALL saturate, and SHALL never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous presses SHALL yield pulses in the same cycle.
REQ-021 Each pulse output SHALL be high for exactly one cycle per accepted press.

Reset
REQ-022 Reset SHALL set all FSMs to ARM, counters to 0, synchronizer flops to 0, and all outputs to 0 in the cycle after reset is sampled high.
REQ-023 A button held through reset SHALL produce no pulse until it is released (accepted by ARM) and pressed again.
REQ-024 Reset asserted mid-debounce SHALL abort the operation with no pulse emitted.

Configuration
REQ-025 Macro BTN_RELEASE_PULSE_EN SHALL select release pulses.
REQ-026 When BTN_RELEASE_PULSE_EN is defined, start_rel_pulse and react_rel_pulse SHALL exist and pulse for one cycle on the REL_CHK->IDLE transition.
REQ-027 When BTN_RELEASE_PULSE_EN is undefined, those ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Package btn_pkg SHALL hold the FSM state enum type and the default DEBOUNCE_CYCLES constant.
REQ-029 Sub-module btn_debounce_ch (synchronizer, counter, FSM for one channel) SHALL be instantiated twice; btn_conditioner SHALL contain only instantiation and port mapping.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then start_btn held 0 for 4+2 cycles, then 0->1 held 20 cycles -> start_pulse high exactly one cycle, 6 cycles after the edge; start_level=1 from that cycle.
REQ-031 react_btn bounces 1,0,1,0 at single-cycle spacing, then stays 1 -> exactly one react_pulse, 6 cycles after the last 0->1.
REQ-032 start_btn held 1 across reset and for 50 cycles after -> no start_pulse; release then press -> one pulse.
REQ-033 Both buttons rise in the same cycle after arming -> start_pulse and react_pulse asserted in the same cycle.
REQ-034 Reset asserted 2 cycles into PRESS_CHK -> no pulse, outputs 0 the next cycle; FSM back in ARM.
REQ-035 With BTN_RELEASE_PULSE_EN defined, press accepted, then 1->0 -> start_rel_pulse one cycle, 6 cycles after the fall; start_level drops in the same cycle.
